// File: rtl/shadow_rc_sched.sv
// Round-constant scheduler for the Shadow-512 permutation: presents one step's
// per-bundle xtime constants per handshake and pulses done after the last step.
module shadow_rc_sched #(
    parameter int          NSTEPS   = 12,
    parameter int          NBUNDLES = 4,
    parameter logic [31:0] RC_INIT  = 32'h0000_0001,
    localparam int         SW       = (NSTEPS > 1) ? $clog2(NSTEPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     rc_valid,
    input  logic                     rc_ready,
    output logic [SW-1:0]            rc_step,
    output logic                     rc_last,
    output logic [32*NBUNDLES-1:0]   rc_out,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

    state_t        state;
    logic [31:0]   w;
    logic [SW-1:0] step;
    logic          busy_q;
    logic          valid_q;
    logic          done_q;
    logic          xfer;

    function automatic logic [31:0] xtime(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ {23'b0, x[31], 7'b0, x[31]};
    endfunction

    // slot[b] = xtime^b(w); the extra tail entry is the next step's state.
    logic [31:0] slot [NBUNDLES+1];
    assign slot[0] = w;

    for (genvar b = 0; b < NBUNDLES; b++) begin : g_chain
        assign slot[b+1]         = xtime(slot[b]);
        assign rc_out[32*b +: 32] = valid_q ? slot[b] : 32'd0;
    end

    assign xfer     = valid_q & rc_ready;
    assign busy     = busy_q;
    assign rc_valid = valid_q;
    assign done     = done_q;
    assign rc_step  = step;
    assign rc_last  = valid_q & (step == LAST_STEP);

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            w       <= 32'd0;
            step    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            // Abort wins over start, a pending transfer and the done pulse.
            state   <= IDLE;
            w       <= 32'd0;
            step    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        w       <= RC_INIT;
                        step    <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (step == LAST_STEP) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            step <= step + SW'(1);
                            w    <= slot[NBUNDLES];
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    w      <= 32'd0;
                    step   <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    w       <= 32'd0;
                    step    <= '0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
